gate_event_counter: RTL and testbench

- Downstream consumer of the power-of-two / ÷20 clock divider output.
- Uses the divider's registered square wave as a measurement gate.
- Counts rising edges of an external, asynchronous signal while the gate is high.
- On each gate falling edge, latches the count and pulses a valid strobe. This is the core of the frequency-meter path feeding the display/BCD stage.

---
 rtl/gate_cnt_pkg.sv | 21 ++
 rtl/gate_event_counter_sync_edge_det.sv | 54 +++++
 rtl/gate_event_counter.sv | 147 ++++++++++++++
 tb/tb_gate_event_counter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/gate_cnt_pkg.sv
// gate_cnt_pkg
// Shared definitions for the gated event counter slice.
//   - gate_state_e   : measurement FSM states (2-bit encoding)
//   - DEF_CNT_W      : default event counter / result width
//   - DEF_SYNC_STAGES: default synchronizer depth on the measured signal
//   - DEF_SAT_MAX    : saturation value of a DEF_CNT_W-wide counter
package gate_cnt_pkg;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;

  // All-ones at the default width; the counter sticks here instead of wrapping.
  localparam logic [DEF_CNT_W-1:0] DEF_SAT_MAX = '1;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    ARMED    = 2'd1,
    COUNT    = 2'd2
  } gate_state_e;

endpackage

// File: rtl/gate_event_counter_sync_edge_det.sv
// sync_edge_det
// Brings an asynchronous level into the clk domain through SYNC_STAGES
// flops, then compares the synchronized value against a one-cycle-old copy
// to produce single-cycle edge strobes.
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-high reset, clears every flop to 0
//   din  in   asynchronous input level
//   rise out  1 for one cycle after din goes 0->1 (synchronized)
//   fall out  1 for one cycle after din goes 1->0 (0 when GEN_FALL=0)
// Parameters:
//   SYNC_STAGES  synchronizer depth, legal range 2..3
//   GEN_FALL     build the falling-edge detector
module sync_edge_det
  import gate_cnt_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter bit GEN_FALL    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   s_sync;

  assign s_sync = sync_q[SYNC_STAGES-1];

  // Synchronizer chain plus the edge-detect history flop.  The first stage
  // may go metastable; only the last stage is ever looked at by logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= s_sync;
    end
  end

  assign rise = s_sync & ~prev_q;

  // The falling detector is only elaborated when a consumer wants it.
  if (GEN_FALL) begin : g_fall
    assign fall = ~s_sync & prev_q;
  end else begin : g_no_fall
    assign fall = 1'b0;
  end

endmodule

// File: rtl/gate_event_counter.sv
// gate_event_counter
// Frequency-meter front end: counts synchronized edges of sig_in while the
// divider-generated gate is high, then latches the total on the gate's
// falling edge and strobes valid for one cycle.
// Ports:
//   clk        in   system clock (same as the divider)
//   rst        in   synchronous active-high reset
//   gate       in   measurement window, already synchronous to clk
//   sig_in     in   asynchronous signal under measurement
//   count_out  out  last latched event count (CNT_W bits), held between strobes
//   valid      out  one-cycle strobe when count_out updates
//   overflow   out  the last window saturated the counter; updates with valid
//   busy       out  high while a window is being counted
// Configuration macro:
//   GATE_CNT_BOTH_EDGE_EN  count both rising and falling sig_in edges
module gate_event_counter
  import gate_cnt_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gate,
  input  logic             sig_in,
  output logic [CNT_W-1:0] count_out,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  localparam logic [CNT_W-1:0] SAT_MAX = '1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  gate_state_e      state, state_nxt;
  logic             gate_q;
  logic             gate_rise, gate_fall;
  logic             sig_rise;
  logic             evt;
  logic [CNT_W-1:0] counter;
  logic             sat;
  logic             at_max;
  logic             clear_cnt;
  logic             latch_res;

`ifdef GATE_CNT_BOTH_EDGE_EN
  logic sig_fall;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES),
    .GEN_FALL    (1'b1)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sig_in),
    .rise (sig_rise),
    .fall (sig_fall)
  );

  assign evt = sig_rise | sig_fall;
`else
  logic fall_unused;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES),
    .GEN_FALL    (1'b0)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sig_in),
    .rise (sig_rise),
    .fall (fall_unused)
  );

  assign evt = sig_rise;
`endif

  // Gate delay flop used for edge detection; gate is already in the clk
  // domain so it needs no synchronizer.
  always_ff @(posedge clk) begin
    if (rst) gate_q <= 1'b0;
    else     gate_q <= gate;
  end

  assign gate_rise = gate & ~gate_q;
  assign gate_fall = ~gate & gate_q;
  assign at_max    = (counter == SAT_MAX);
  assign busy      = (state == COUNT);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_LOW;
    else     state <= state_nxt;
  end

  // Next-state and control decode.  WAIT_LOW insists on seeing gate low
  // first so a window already in progress at reset is never measured.
  always_comb begin
    state_nxt = state;
    clear_cnt = 1'b0;
    latch_res = 1'b0;
    unique case (state)
      WAIT_LOW: if (!gate) state_nxt = ARMED;
      ARMED: begin
        if (gate_rise) begin
          clear_cnt = 1'b1;
          state_nxt = COUNT;
        end
      end
      COUNT: begin
        if (gate_fall) begin
          latch_res = 1'b1;
          state_nxt = ARMED;
        end
      end
      default: state_nxt = WAIT_LOW;
    endcase
  end

  // Counter and result registers.  sat records an event that arrived while
  // the counter was already at its maximum, i.e. at least one event was
  // lost.  The latch includes an event coincident with gate_fall, so the
  // final increment is folded in here rather than waiting one more cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter   <= '0;
      sat       <= 1'b0;
      count_out <= '0;
      overflow  <= 1'b0;
      valid     <= 1'b0;
    end else begin
      valid <= latch_res;
      if (clear_cnt) begin
        counter <= '0;
        sat     <= 1'b0;
      end else if (busy && evt) begin
        if (at_max) sat     <= 1'b1;
        else        counter <= counter + ONE;
      end
      if (latch_res) begin
        count_out <= (evt && !at_max) ? counter + ONE : counter;
        overflow  <= sat | (evt & at_max);
      end
    end
  end

endmodule

// File: tb/tb_gate_event_counter.sv
// tb_gate_event_counter
// Scoreboard bench for gate_event_counter (CNT_W=4 so saturation is easy to
// reach).  A reference model records every sampled gate/sig_in value and
// derives each window's expected result from the recorded history; a
// separate monitor compares whenever the DUT strobes valid and checks the
// held outputs every cycle.
module tb_gate_event_counter;

  localparam int CNT_W       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int SAT_MAX     = (1 << CNT_W) - 1;
  localparam int HIST        = 8192;

  typedef struct {
    int cnt;
    bit ovf;
    int due;
  } exp_t;

  logic             clk    = 1'b0;
  logic             rst    = 1'b1;
  logic             gate   = 1'b0;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] count_out;
  logic             valid;
  logic             overflow;
  logic             busy;

  int   compared   = 0;
  int   mismatched = 0;
  exp_t expQ[$];
  bit   gHist[HIST];
  bit   sHist[HIST];
  int   edgeNo  = 0;
  int   rstEdge = -1000;
  bit   inWin   = 1'b0;
  int   winCnt  = 0;
  int   holdCnt = 0;
  bit   holdOvf = 1'b0;

  gate_event_counter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .gate      (gate),
    .sig_in    (sig_in),
    .count_out (count_out),
    .valid     (valid),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Sampled values at or before the last reset edge are treated as 0,
  // because reset clears every flop that remembers them.
  function automatic bit sAt(int k);
    if (k < 0 || k <= rstEdge) return 1'b0;
    return sHist[k];
  endfunction

  function automatic bit gAt(int k);
    if (k < 0 || k <= rstEdge) return 1'b0;
    return gHist[k];
  endfunction

  // An input transition sampled at edge k reaches the counter at edge
  // k+SYNC_STAGES.
  function automatic bit eventAt(int c);
    bit a;
    bit b;
    a = sAt(c - SYNC_STAGES);
    b = sAt(c - SYNC_STAGES - 1);
`ifdef GATE_CNT_BOTH_EDGE_EN
    return a ^ b;
`else
    return a & ~b;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", name, edgeNo, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic g, input logic s, input logic r);
    @(negedge clk);
    gate   = g;
    sig_in = s;
    rst    = r;
  endtask

  // Reference model: window = first qualifying gate rise (at least two
  // edges after reset) through the next gate fall; events counted on the
  // edges after the rise up to and including the fall.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      edgeNo++;
      if (edgeNo >= HIST) begin
        $display("[TB] FAIL history_overflow at edge %0d", edgeNo);
        $fatal(1, "[TB] history exhausted");
      end
      gHist[edgeNo] = gate;
      sHist[edgeNo] = sig_in;
      if (rst) begin
        rstEdge = edgeNo;
        inWin   = 1'b0;
        winCnt  = 0;
      end else if (inWin) begin
        if (eventAt(edgeNo)) winCnt++;
        if (!gate) begin
          e.cnt = (winCnt > SAT_MAX) ? SAT_MAX : winCnt;
          e.ovf = (winCnt > SAT_MAX);
          e.due = edgeNo;
          expQ.push_back(e);
          inWin = 1'b0;
        end
      end else if (gate && !gAt(edgeNo - 1) && edgeNo >= rstEdge + 2) begin
        inWin  = 1'b1;
        winCnt = 0;
      end
    end
  end

  // Monitor: pops one expectation per valid strobe, flags spurious or
  // missing strobes, and checks held outputs and busy every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (edgeNo > 0) begin
        if (edgeNo == rstEdge) begin
          holdCnt = 0;
          holdOvf = 1'b0;
          checkOutput("reset_valid", valid, 0);
        end else if (valid === 1'b1) begin
          if (expQ.size() == 0) begin
            checkOutput("spurious_valid", valid, 0);
          end else begin
            e = expQ.pop_front();
            checkOutput("valid_latency", edgeNo, e.due);
            holdCnt = e.cnt;
            holdOvf = e.ovf;
          end
        end else if (expQ.size() > 0 && expQ[0].due <= edgeNo) begin
          e = expQ.pop_front();
          checkOutput("missing_valid", valid, 1);
        end
        checkOutput("count_out", count_out, holdCnt);
        checkOutput("overflow", overflow, holdOvf);
        checkOutput("busy", busy, inWin);
      end
    end
  end

  initial begin
    int hi;
    int lo;
    repeat (3) applyStimulus(0, 0, 1);
    repeat (3) applyStimulus(0, 0, 0);

    // 20-cycle window, 5 pulses spaced 4; the last lands on gate_fall.
    for (int i = 0; i < 20; i++) applyStimulus(1, (i % 4) == 2, 0);
    repeat (10) applyStimulus(0, 0, 0);

    // 4 pulses inside, one that arrives a cycle after gate_fall.
    for (int i = 0; i < 20; i++)
      applyStimulus(1, (i == 2 || i == 6 || i == 10 || i == 14 || i == 19), 0);
    repeat (10) applyStimulus(0, 0, 0);

    // Reset in the middle of a window that has already counted several edges.
    for (int i = 0; i < 18; i++) applyStimulus(1, (i % 2) == 1, 0);
    repeat (2) applyStimulus(1, 0, 1);
    repeat (5) applyStimulus(1, 1, 0);
    repeat (3) applyStimulus(0, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1, (i == 1 || i == 4), 0);
    repeat (5) applyStimulus(0, 0, 0);

    // Saturation, then a normal window that must clear overflow.
    for (int i = 0; i < 45; i++) applyStimulus(1, (i % 2) == 1, 0);
    repeat (5) applyStimulus(0, 0, 0);
    for (int i = 0; i < 12; i++) applyStimulus(1, (i == 2 || i == 5 || i == 8), 0);
    repeat (5) applyStimulus(0, 0, 0);

    // Single-cycle gate with no edges, then back-to-back windows.
    applyStimulus(1, 0, 0);
    repeat (4) applyStimulus(0, 0, 0);
    repeat (3) applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    repeat (3) applyStimulus(1, 0, 0);
    repeat (5) applyStimulus(0, 0, 0);

    // Randomized windows and signal, with one reset dropped in mid-run.
    for (int r = 0; r < 60; r++) begin
      hi = $urandom_range(1, 10);
      lo = $urandom_range(1, 6);
      for (int i = 0; i < hi; i++) applyStimulus(1, 1'($urandom_range(0, 1)), 0);
      if (r == 30) applyStimulus(1, 0, 1);
      for (int i = 0; i < lo; i++) applyStimulus(0, 1'($urandom_range(0, 1)), 0);
    end

    repeat (6) applyStimulus(0, 0, 0);
    checkOutput("queue_drained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
